// File: rtl/cro_puf_axi_pkg.sv
// Shared types, response codes and sizing helpers for the CRO PUF AXI4 burst memory.
package cro_puf_axi_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WDATA = 2'b01,
      WRESP = 2'b10,
      RDATA = 2'b11
   } state_e;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   // One spare bit keeps beats just past the top of memory distinguishable from low words.
   function automatic int addr_width(input int mem_depth, input int data_width);
      return $clog2(mem_depth) + $clog2(data_width / 8) + 1;
   endfunction

   function automatic logic burst_illegal(input logic [1:0] burst, input logic [7:0] len);
      logic bad;
      case (burst)
         BURST_WRAP: bad = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
         BURST_RSVD: bad = 1'b1;
         default:    bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/cro_puf_axi_addr_gen.sv
// Next word address of an AXI burst: FIXED holds, INCR steps, WRAP stays inside its aligned window.
module cro_puf_axi_addr_gen
   import cro_puf_axi_pkg::*;
#(
   parameter int WA = 16
) (
   input  logic [WA-1:0] addr_i,
   input  logic [1:0]    burst_i,
   input  logic [7:0]    len_i,
   output logic [WA-1:0] next_o
);

   localparam logic [WA-1:0] ONE = WA'(1'b1);

   logic [WA-1:0] step_s;
   logic [WA-1:0] mask_s;

   // A legal wrap length is 2^n-1, so it doubles as the in-window offset mask.
   always_comb begin
      step_s = addr_i + ONE;
      mask_s = WA'(len_i);
      case (burst_i)
         BURST_INCR: next_o = step_s;
         BURST_WRAP: next_o = (addr_i & ~mask_s) | (step_s & mask_s);
         default:    next_o = addr_i;
      endcase
   end

endmodule

// File: rtl/cro_puf_axi4_burst_mem.sv
// AXI4 slave memory with exactly one burst in flight; a simultaneous AW/AR request is won by the write.
module cro_puf_axi4_burst_mem
   import cro_puf_axi_pkg::*;
#(
   parameter int  C_S_AXI_DATA_WIDTH = 32,
   parameter int  C_S_AXI_ID_WIDTH   = 1,
   parameter int  C_MEM_DEPTH        = 64,
   localparam int AW = addr_width(C_MEM_DEPTH, C_S_AXI_DATA_WIDTH)
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
   input  logic [AW-1:0]                   S_AXI_AWADDR,
   input  logic [7:0]                      S_AXI_AWLEN,
   input  logic [1:0]                      S_AXI_AWBURST,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WLAST,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
   input  logic [AW-1:0]                   S_AXI_ARADDR,
   input  logic [7:0]                      S_AXI_ARLEN,
   input  logic [1:0]                      S_AXI_ARBURST,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RLAST,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY
);

   localparam int DW  = C_S_AXI_DATA_WIDTH;
   localparam int SW  = C_S_AXI_DATA_WIDTH / 8;
   localparam int IW  = C_S_AXI_ID_WIDTH;
   localparam int OFF = $clog2(SW);
   localparam int IDX = $clog2(C_MEM_DEPTH);
   // Word address carries 9 headroom bits so a 256-beat INCR never wraps back into range.
   localparam int WA  = AW - OFF + 9;
   localparam logic [WA-1:0] DEPTH_W = WA'(C_MEM_DEPTH);

   state_e          state_q, state_d;
   logic [IW-1:0]   id_q, id_d;
   logic [7:0]      len_q, len_d;
   logic [7:0]      beat_q, beat_d;
   logic [1:0]      burst_q, burst_d;
   logic [WA-1:0]   addr_q, addr_d;
   logic            ill_q, ill_d;
   logic            err_q, err_d;
   logic            rdy_q, rdy_d;
   logic [WA-1:0]   next_s;
   logic [WA-1:0]   aw_word_s;
   logic [WA-1:0]   ar_word_s;
   logic            last_s;
   logic            in_rng_s;
   logic            we_s;
   logic            re_s;
   logic [IDX-1:0]  ram_idx_s;
   logic [DW-1:0]   mem_q [C_MEM_DEPTH];
   logic [DW-1:0]   rd_word_q;

   assign aw_word_s = WA'(S_AXI_AWADDR >> OFF);
   assign ar_word_s = WA'(S_AXI_ARADDR >> OFF);
   assign last_s    = (beat_q == len_q);
   assign in_rng_s  = (addr_q < DEPTH_W);

   cro_puf_axi_addr_gen #(.WA(WA)) u_addr_gen (
      .addr_i  (addr_q),
      .burst_i (burst_q),
      .len_i   (len_q),
      .next_o  (next_s)
   );

   // Burst sequencing; err_q accumulates for writes but tracks the current beat for reads.
   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      len_d     = len_q;
      burst_d   = burst_q;
      addr_d    = addr_q;
      beat_d    = beat_q;
      ill_d     = ill_q;
      err_d     = err_q;
      we_s      = 1'b0;
      re_s      = 1'b0;
      ram_idx_s = addr_q[IDX-1:0];
      case (state_q)
         IDLE: begin
            if (S_AXI_AWVALID && rdy_q) begin
               state_d = WDATA;
               id_d    = S_AXI_AWID;
               len_d   = S_AXI_AWLEN;
               burst_d = S_AXI_AWBURST;
               addr_d  = aw_word_s;
               beat_d  = 8'd0;
               ill_d   = burst_illegal(S_AXI_AWBURST, S_AXI_AWLEN);
               err_d   = ill_d;
            end else if (S_AXI_ARVALID && rdy_q) begin
               state_d   = RDATA;
               id_d      = S_AXI_ARID;
               len_d     = S_AXI_ARLEN;
               burst_d   = S_AXI_ARBURST;
               addr_d    = ar_word_s;
               beat_d    = 8'd0;
               ill_d     = burst_illegal(S_AXI_ARBURST, S_AXI_ARLEN);
               err_d     = ill_d || (ar_word_s >= DEPTH_W);
               re_s      = 1'b1;
               ram_idx_s = ar_word_s[IDX-1:0];
            end else begin
               state_d = IDLE;
            end
         end
         WDATA: begin
            if (S_AXI_WVALID) begin
               we_s   = !ill_q && in_rng_s;
               err_d  = err_q || !in_rng_s || (S_AXI_WLAST != last_s);
               addr_d = next_s;
               if (last_s) begin
                  state_d = WRESP;
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end else begin
               state_d = WDATA;
            end
         end
         WRESP: begin
            if (S_AXI_BREADY) begin
               state_d = IDLE;
            end else begin
               state_d = WRESP;
            end
         end
         RDATA: begin
            if (S_AXI_RREADY && last_s) begin
               state_d = IDLE;
            end else if (S_AXI_RREADY) begin
               beat_d    = beat_q + 8'd1;
               addr_d    = next_s;
               err_d     = ill_q || (next_s >= DEPTH_W);
               re_s      = 1'b1;
               ram_idx_s = next_s[IDX-1:0];
            end else begin
               state_d = RDATA;
            end
         end
         default: state_d = IDLE;
      endcase
      rdy_d = (state_d == IDLE);
   end

   // Control state; rdy_q keeps the address channels closed until the first edge after reset.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         state_q <= IDLE;
         id_q    <= '0;
         len_q   <= 8'd0;
         beat_q  <= 8'd0;
         burst_q <= 2'b00;
         addr_q  <= '0;
         ill_q   <= 1'b0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         burst_q <= burst_d;
         addr_q  <= addr_d;
         ill_q   <= ill_d;
         err_q   <= err_d;
         rdy_q   <= rdy_d;
      end
   end

   // Single-port storage with byte-lane writes and registered reads, never cleared.
   always_ff @(posedge S_AXI_ACLK) begin
      for (int b = 0; b < SW; b++) begin
         if (we_s && S_AXI_WSTRB[b]) begin
            mem_q[ram_idx_s][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
         end
      end
      if (re_s) begin
         rd_word_q <= mem_q[ram_idx_s];
      end
   end

   assign S_AXI_AWREADY = rdy_q;
   assign S_AXI_ARREADY = rdy_q && !S_AXI_AWVALID;
   assign S_AXI_WREADY  = (state_q == WDATA);
   assign S_AXI_BVALID  = (state_q == WRESP);
   assign S_AXI_BID     = id_q;
   assign S_AXI_BRESP   = (state_q == WRESP && err_q) ? SLVERR : OKAY;
   assign S_AXI_RVALID  = (state_q == RDATA);
   assign S_AXI_RID     = id_q;
   assign S_AXI_RDATA   = (state_q == RDATA && !err_q) ? rd_word_q : '0;
   assign S_AXI_RRESP   = (state_q == RDATA && err_q) ? SLVERR : OKAY;
   assign S_AXI_RLAST   = (state_q == RDATA) && last_s;

endmodule

// File: tb/tb_cro_puf_axi4_burst_mem.sv
// Directed and randomized bursts against cro_puf_axi4_burst_mem, checked with a beat-level reference model.
module tb_cro_puf_axi4_burst_mem;
   import cro_puf_axi_pkg::*;

   localparam int DW    = 32;
   localparam int IW    = 1;
   localparam int DEPTH = 64;
   localparam int AW    = addr_width(DEPTH, DW);
   localparam logic [1:0] B_FIXED = 2'b00;
   localparam logic [1:0] B_INCR  = 2'b01;
   localparam logic [1:0] B_WRAP  = 2'b10;
   localparam logic [1:0] B_RSVD  = 2'b11;

   logic          clk = 1'b0;
   logic          rst;
   logic [IW-1:0] awid, bid, arid, rid;
   logic [AW-1:0] awaddr, araddr;
   logic [7:0]    awlen, arlen;
   logic [1:0]    awburst, arburst, bresp, rresp;
   logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic          arvalid, arready, rvalid, rready, rlast;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model [DEPTH];
   logic [31:0] wd [256];
   logic [3:0]  ws [256];

   always #5 clk = ~clk;

   cro_puf_axi4_burst_mem #(
      .C_S_AXI_DATA_WIDTH (DW),
      .C_S_AXI_ID_WIDTH   (IW),
      .C_MEM_DEPTH        (DEPTH)
   ) dut (
      .S_AXI_ACLK    (clk),     .S_AXI_ARESET  (rst),
      .S_AXI_AWID    (awid),    .S_AXI_AWADDR  (awaddr),  .S_AXI_AWLEN   (awlen),
      .S_AXI_AWBURST (awburst), .S_AXI_AWVALID (awvalid), .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),   .S_AXI_WSTRB   (wstrb),   .S_AXI_WLAST   (wlast),
      .S_AXI_WVALID  (wvalid),  .S_AXI_WREADY  (wready),
      .S_AXI_BID     (bid),     .S_AXI_BRESP   (bresp),   .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARID    (arid),    .S_AXI_ARADDR  (araddr),  .S_AXI_ARLEN   (arlen),
      .S_AXI_ARBURST (arburst), .S_AXI_ARVALID (arvalid), .S_AXI_ARREADY (arready),
      .S_AXI_RID     (rid),     .S_AXI_RDATA   (rdata),   .S_AXI_RRESP   (rresp),
      .S_AXI_RLAST   (rlast),   .S_AXI_RVALID  (rvalid),  .S_AXI_RREADY  (rready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit legal(input logic [1:0] burst, input int len);
      if (burst == B_RSVD) return 1'b0;
      if (burst == B_WRAP) return (len == 1 || len == 3 || len == 7 || len == 15);
      return 1'b1;
   endfunction

   // Word touched by beat i, straight from the burst rules.
   function automatic int beat_word(input int start, input logic [1:0] burst, input int len, input int i);
      int n;
      int base;
      if (burst == B_FIXED) return start;
      if (burst == B_WRAP) begin
         n    = len + 1;
         base = start - (start % n);
         return base + ((start - base + i) % n);
      end
      return start + i;
   endfunction

   // All bus tasks start and end 1ns after a rising edge.
   task automatic wr_burst(input logic [IW-1:0] id, input int word, input int len,
                           input logic [1:0] burst, input int early_last, input bit tie);
      bit err;
      int wa;
      int n;
      int dly;
      err = !legal(burst, len);
      awid = id; awaddr = AW'(word * 4); awlen = 8'(len); awburst = burst; awvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!awready && n < 40);
      chk("aw_ready", awready, 1'b1);
      if (tie) begin
         chk("tie_arready_low", arready, 1'b0);
      end
      @(posedge clk); #1;
      awvalid = 1'b0;
      for (int i = 0; i <= len; i++) begin
         wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
         wlast  = (early_last >= 0) ? (i == early_last) : (i == len);
         if (wlast != (i == len)) err = 1'b1;
         wa = beat_word(word, burst, len, i);
         if (wa >= DEPTH) begin
            err = 1'b1;
         end else if (legal(burst, len)) begin
            for (int b = 0; b < 4; b++) if (ws[i][b]) model[wa][8*b +: 8] = wd[i][8*b +: 8];
         end
         n = 0;
         do begin @(negedge clk); n++; end while (!wready && n < 40);
         chk("w_ready", wready, 1'b1);
         @(posedge clk); #1;
      end
      wvalid = 1'b0; wlast = 1'b0;
      dly = $urandom_range(0, 2);
      for (int k = 0; k < dly; k++) begin @(posedge clk); #1; end
      bready = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bvalid && n < 40);
      chk("b_valid", bvalid, 1'b1);
      chk("b_resp", bresp, err ? 2'b10 : 2'b00);
      chk("b_id", bid, id);
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   task automatic ar_phase(input logic [IW-1:0] id, input int word, input int len, input logic [1:0] burst);
      int n;
      arid = id; araddr = AW'(word * 4); arlen = 8'(len); arburst = burst; arvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!arready && n < 40);
      chk("ar_ready", arready, 1'b1);
      @(posedge clk); #1;
      arvalid = 1'b0;
   endtask

   task automatic r_beat(input logic [IW-1:0] id, input int word, input int len, input logic [1:0] burst, input int i);
      bit          err;
      int          wa;
      int          n;
      int          stall;
      logic [31:0] exp_d;
      err = !legal(burst, len);
      wa  = beat_word(word, burst, len, i);
      if (!err && wa >= DEPTH) err = 1'b1;
      if (err) exp_d = 32'h0;
      else     exp_d = model[wa];
      stall = $urandom_range(0, 2);
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         chk("r_hold_valid", rvalid, 1'b1);
         chk("r_hold_data", rdata, exp_d);
         @(posedge clk); #1;
      end
      rready = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!rvalid && n < 40);
      if (i == 0) chk("r_first_latency", n, 1);
      chk("r_data", rdata, exp_d);
      chk("r_resp", rresp, err ? 2'b10 : 2'b00);
      chk("r_last", rlast, (i == len) ? 1'b1 : 1'b0);
      chk("r_id", rid, id);
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   task automatic rd_burst(input logic [IW-1:0] id, input int word, input int len, input logic [1:0] burst);
      ar_phase(id, word, len, burst);
      for (int i = 0; i <= len; i++) r_beat(id, word, len, burst, i);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [1:0] bu;
      int         ln;
      int         sw;
      rst = 1'b1;
      awid = '0; awaddr = '0; awlen = 8'd0; awburst = 2'b00; awvalid = 1'b0;
      wdata = 32'h0; wstrb = 4'h0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      arid = '0; araddr = '0; arlen = 8'd0; arburst = 2'b00; arvalid = 1'b0; rready = 1'b0;

      // Reset values, then ready rising on the first edge after release.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_awready", awready, 1'b0);
      chk("rst_arready", arready, 1'b0);
      chk("rst_wready", wready, 1'b0);
      chk("rst_bvalid", bvalid, 1'b0);
      chk("rst_rvalid", rvalid, 1'b0);
      chk("rst_rlast", rlast, 1'b0);
      chk("rst_bresp", bresp, 2'b00);
      chk("rst_rresp", rresp, 2'b00);
      chk("rst_rdata", rdata, 32'h0);
      rst = 1'b0;
      #1;
      chk("rel_awready_before_edge", awready, 1'b0);
      @(posedge clk); #1;
      chk("rel_awready", awready, 1'b1);
      chk("rel_arready", arready, 1'b1);

      // Fill every word so later reads have known contents.
      for (int i = 0; i < DEPTH; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      wr_burst(1'b0, 0, DEPTH - 1, B_INCR, -1, 1'b0);

      // INCR LEN=7, data 1..8.
      for (int i = 0; i < 8; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
      wr_burst(1'b1, 0, 7, B_INCR, -1, 1'b0);
      rd_burst(1'b1, 0, 7, B_INCR);

      // WRAP LEN=3 from byte 0x8, read back linearly from 0x0.
      wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
      for (int i = 0; i < 4; i++) ws[i] = 4'hF;
      wr_burst(1'b0, 2, 3, B_WRAP, -1, 1'b0);
      rd_burst(1'b0, 0, 3, B_INCR);
      rd_burst(1'b1, 2, 3, B_WRAP);

      // AW and AR together to the same word: write of 9 over 5 goes first.
      wd[0] = 32'd5; ws[0] = 4'hF;
      wr_burst(1'b0, 20, 0, B_INCR, -1, 1'b0);
      arid = 1'b1; araddr = AW'(20 * 4); arlen = 8'd0; arburst = B_INCR; arvalid = 1'b1;
      wd[0] = 32'd9;
      wr_burst(1'b0, 20, 0, B_INCR, -1, 1'b1);
      rd_burst(1'b1, 20, 0, B_INCR);

      // INCR crossing the top of memory.
      for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      wr_burst(1'b0, 62, 3, B_INCR, -1, 1'b0);
      rd_burst(1'b0, 62, 3, B_INCR);

      // Partial strobes, then an early WLAST.
      wd[0] = 32'h0; ws[0] = 4'hF;
      wr_burst(1'b0, 30, 0, B_INCR, -1, 1'b0);
      wd[0] = 32'hFFFF_FFFF; ws[0] = 4'b0101;
      wr_burst(1'b0, 30, 0, B_INCR, -1, 1'b0);
      rd_burst(1'b0, 30, 0, B_INCR);
      for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      wr_burst(1'b1, 40, 3, B_INCR, 1, 1'b0);
      rd_burst(1'b1, 40, 3, B_INCR);

      // Illegal wrap length, reserved burst type, and FIXED.
      for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      wr_burst(1'b0, 44, 2, B_WRAP, -1, 1'b0);
      rd_burst(1'b0, 44, 2, B_WRAP);
      rd_burst(1'b0, 44, 3, B_INCR);
      wr_burst(1'b0, 48, 1, B_RSVD, -1, 1'b0);
      rd_burst(1'b1, 48, 1, B_RSVD);
      wr_burst(1'b0, 10, 3, B_FIXED, -1, 1'b0);
      rd_burst(1'b0, 10, 3, B_FIXED);

      // Randomized bursts against the model.
      for (int t = 0; t < 24; t++) begin
         bu = 2'($urandom_range(0, 3));
         if (bu == B_WRAP) ln = ($urandom_range(0, 4) == 0) ? 5 : (1 << $urandom_range(1, 4)) - 1;
         else ln = $urandom_range(0, 9);
         sw = $urandom_range(0, 70);
         for (int i = 0; i <= ln; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
         wr_burst(1'($urandom_range(0, 1)), sw, ln, bu, -1, 1'b0);
         rd_burst(1'($urandom_range(0, 1)), sw, ln, bu);
         rd_burst(1'b0, $urandom_range(0, 60), 3, B_INCR);
      end

      // Reset while beat 2 of an 8-beat read is on the bus.
      ar_phase(1'b0, 0, 7, B_INCR);
      r_beat(1'b0, 0, 7, B_INCR, 0);
      r_beat(1'b0, 0, 7, B_INCR, 1);
      #2;
      chk("pre_reset_rvalid", rvalid, 1'b1);
      rst = 1'b1;
      #1;
      chk("mid_reset_rvalid", rvalid, 1'b0);
      chk("mid_reset_rdata", rdata, 32'h0);
      chk("mid_reset_rlast", rlast, 1'b0);
      chk("mid_reset_arready", arready, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      rd_burst(1'b1, 0, 7, B_INCR);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
